// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared constants, types and the result-byte helper for the 3x3 matrix
// multiply engine (matmul_engine + mac_unit).
//
// Build option: MATMUL_SIGNED_EN (the arithmetic switch lives in mac_unit).
// -----------------------------------------------------------------------------
package matmul_pkg;

  localparam int N      = 3;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 2 * DATA_W + $clog2(N);  // 18
  localparam int OUT_B  = 3;
  localparam int ELEMS  = N * N;                   // 9
  localparam int BYTES  = ELEMS * OUT_B;           // 27

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [ACC_W-1:0]  acc_t;
  typedef logic [DATA_W-1:0] data_t;

  // One byte of a result element, LSB byte first. The top byte carries
  // c[17:16] with the remaining six bits padded: zero for unsigned results,
  // copies of c[17] when the engine runs two's complement.
  function automatic logic [7:0] result_byte(input acc_t c, input logic [1:0] sel,
                                             input logic sign_ext);
    logic [7:0] b;
    case (sel)
      2'd0:    b = c[7:0];
      2'd1:    b = c[15:8];
      default: b = {{6{sign_ext & c[17]}}, c[17:16]};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// -----------------------------------------------------------------------------
// mac_unit
// Single shared multiply-accumulate for the matrix engine: one 8x8 product per
// enabled cycle, either loaded fresh (clr_i) or added to the running sum.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   en_i           update the accumulator this cycle
//   clr_i          start a new dot product (ignore the held accumulator)
//   a_i, b_i       operand pair
//   sum_o          combinational accumulator-plus-product (next accumulator)
//   signed_mode_o  constant: 1 when arithmetic is two's complement
//
// Build option: MATMUL_SIGNED_EN selects signed operands and products.
// -----------------------------------------------------------------------------
module mac_unit
  import matmul_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en_i,
  input  logic  clr_i,
  input  data_t a_i,
  input  data_t b_i,
  output acc_t  sum_o,
  output logic  signed_mode_o
);

  acc_t acc_q;
  acc_t prod;

`ifdef MATMUL_SIGNED_EN
  logic signed [2*DATA_W-1:0] prod_s;
  assign prod_s        = $signed(a_i) * $signed(b_i);
  assign prod          = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
  assign signed_mode_o = 1'b1;
`else
  logic [2*DATA_W-1:0] prod_u;
  assign prod_u        = a_i * b_i;
  assign prod          = {{(ACC_W-2*DATA_W){1'b0}}, prod_u};
  assign signed_mode_o = 1'b0;
`endif

  // The sum is exported combinationally so the engine can capture the final
  // dot product on the same edge the accumulator absorbs the last term.
  assign sum_o = (clr_i ? '0 : acc_q) + prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// -----------------------------------------------------------------------------
// matmul_engine
// Computes C = A x B for 3x3 byte matrices using one shared MAC (27 cycles),
// then streams the nine 18-bit results out as 27 bytes, element-major and
// LSB byte first, over a valid/ready port.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 loader done flag (level, rising edge triggers a pass)
//   a_in[0:8], b_in[0:8]  operand matrices, row-major
//   out_data              current result byte (0 when not streaming)
//   out_valid             out_data holds a byte
//   out_ready             sink accepts the byte
//   busy                  high while computing or streaming
//   finished              high after all 27 bytes were transferred
//   state_dbg_o           current FSM state for observation
//
// Handshake: a byte transfers on a rising clk edge where out_valid and
// out_ready are both high; out_valid never drops and out_data never changes
// until that transfer happens, and out_ready may be high at any time.
//
// Build option: MATMUL_SIGNED_EN (two's complement arithmetic, sign-extended pad).
// -----------------------------------------------------------------------------
module matmul_engine
  import matmul_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  data_t      a_in [0:ELEMS-1],
  input  data_t      b_in [0:ELEMS-1],
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       finished,
  output state_t     state_dbg_o
);

  state_t     state_q, state_d;
  logic       start_q;
  logic       trig;

  logic [1:0] i_q, i_d;
  logic [1:0] j_q, j_d;
  logic [1:0] k_q, k_d;
  logic [3:0] elem_q, elem_d;
  logic [1:0] bsel_q, bsel_d;

  data_t      a_q [0:ELEMS-1];
  data_t      b_q [0:ELEMS-1];
  acc_t       c_q [0:ELEMS-1];

  logic       load_ops;
  logic       mac_en;
  logic       mac_clr;
  logic       c_we;
  logic       mac_last;
  logic       stream_last;

  logic [3:0] a_idx, b_idx, c_idx;
  data_t      a_op, b_op;
  acc_t       mac_sum;
  logic       signed_mode;

  // A level held high never retriggers: only the 0->1 transition counts.
  assign trig = start & ~start_q;

  assign a_idx = {2'b00, i_q} * 4'd3 + {2'b00, k_q};
  assign b_idx = {2'b00, k_q} * 4'd3 + {2'b00, j_q};
  assign c_idx = {2'b00, i_q} * 4'd3 + {2'b00, j_q};
  assign a_op  = a_q[a_idx];
  assign b_op  = b_q[b_idx];

  assign mac_last    = (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);
  assign stream_last = (elem_q == 4'(ELEMS - 1)) && (bsel_q == 2'(OUT_B - 1));

  mac_unit u_mac (
    .clk           (clk),
    .reset         (reset),
    .en_i          (mac_en),
    .clr_i         (mac_clr),
    .a_i           (a_op),
    .b_i           (b_op),
    .sum_o         (mac_sum),
    .signed_mode_o (signed_mode)
  );

  // ---------------------------------------------------------------------------
  // FSM next state, counter updates and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    elem_d    = elem_q;
    bsel_d    = bsel_q;
    load_ops  = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    c_we      = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    busy      = 1'b0;
    finished  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        finished = (state_q == DONE);
        if (trig) begin
          state_d  = MAC;
          load_ops = 1'b1;
          i_d      = 2'd0;
          j_d      = 2'd0;
          k_d      = 2'd0;
        end
      end

      MAC: begin
        busy    = 1'b1;
        mac_en  = 1'b1;
        // k==0 begins a new dot product; k==2 closes it into c_q.
        mac_clr = (k_q == 2'd0);
        c_we    = (k_q == 2'd2);
        if (mac_last) begin
          state_d = STREAM;
          i_d     = 2'd0;
          j_d     = 2'd0;
          k_d     = 2'd0;
          elem_d  = 4'd0;
          bsel_d  = 2'd0;
        end else if (k_q == 2'd2) begin
          k_d = 2'd0;
          if (j_q == 2'd2) begin
            j_d = 2'd0;
            i_d = i_q + 2'd1;
          end else begin
            j_d = j_q + 2'd1;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Byte selection depends only on registered counters and c_q, so the
        // byte is stable for as long as the sink stalls.
        out_data  = result_byte(c_q[elem_q], bsel_q, signed_mode);
        if (out_ready) begin
          if (stream_last) begin
            state_d = DONE;
          end else if (bsel_q == 2'(OUT_B - 1)) begin
            bsel_d = 2'd0;
            elem_d = elem_q + 4'd1;
          end else begin
            bsel_d = bsel_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_dbg_o = state_q;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      i_q     <= 2'd0;
      j_q     <= 2'd0;
      k_q     <= 2'd0;
      elem_q  <= 4'd0;
      bsel_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      elem_q  <= elem_d;
      bsel_q  <= bsel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand copies and result storage. Operands are captured on the trigger
  // edge so later activity on a_in/b_in cannot disturb a pass.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < ELEMS; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      if (load_ops) begin
        for (int n = 0; n < ELEMS; n++) begin
          a_q[n] <= a_in[n];
          b_q[n] <= b_in[n];
        end
      end
      if (c_we) begin
        c_q[c_idx] <= mac_sum;
      end
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// -----------------------------------------------------------------------------
// tb_matmul_engine
// Directed bench for matmul_engine: identity, all-ones-byte, mixed-sign and a
// general matrix, stalled sink, retrigger attempts and a mid-stream reset.
// Expected result elements are hand-computed constants; the bench splits
// them into the three output bytes it expects.
// -----------------------------------------------------------------------------
module tb_matmul_engine;
  import matmul_pkg::*;

`ifdef MATMUL_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  data_t      a_in [0:ELEMS-1];
  data_t      b_in [0:ELEMS-1];
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       finished;
  state_t     state_dbg;

  always #5 clk = ~clk;

  matmul_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_in        (a_in),
    .b_in        (b_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .finished    (finished),
    .state_dbg_o (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_elem(input logic [17:0] c);
    logic pad;
    pad = SGN & c[17];
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back({{6{pad}}, c[17:16]});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Raise start for one edge (optionally leave it high) and confirm the pass began.
  task automatic kick(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("kick_busy", 32'(busy), 32'd1);
    check("kick_finished", 32'(finished), 32'd0);
    check("kick_valid", 32'(out_valid), 32'd0);
  endtask

  // Take n_take bytes, comparing each against the expected queue. rnd toggles
  // out_ready; span reports cycles from first valid to last transfer.
  task automatic collect(input string tag, input int n_take, input bit rnd, output int span);
    int         got;
    int         cyc;
    int         first;
    bit         stalled;
    logic [7:0] held;
    logic [7:0] exp;
    got     = 0;
    cyc     = 0;
    first   = -1;
    stalled = 1'b0;
    held    = 8'h00;
    while (got < n_take && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(out_data), 32'(held));
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled   = 1'b0;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (out_ready) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check($sformatf("%s_byte%0d", tag, got), 32'(out_data), 32'(exp));
          got++;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end
    end
    check({tag, "_count"}, 32'(got), 32'(n_take));
    span = (first < 0) ? -1 : cyc - first + 1;
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(DONE));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int span;

    a_in = '{default: 8'h00};
    b_in = '{default: 8'h00};
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    // 1: identity x (1..9), ready high before valid -> C = B, back-to-back bytes
    a_in = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    b_in = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    out_ready = 1'b1;
    for (int e = 1; e <= 9; e++) push_elem(18'(e));
    kick(1'b0);
    repeat (20) @(negedge clk);
    check("t1_mac_no_valid", 32'(out_valid), 32'd0);
    check("t1_mac_busy", 32'(busy), 32'd1);
    collect("t1", BYTES, 1'b0, span);
    check("t1_span", 32'(span), 32'd27);
    check_done("t1");

    // 2: all 0xFF x all 0xFF -> 195075 (unsigned) or 3 (signed)
    a_in = '{default: 8'hFF};
    b_in = '{default: 8'hFF};
    for (int e = 0; e < 9; e++) push_elem(SGN ? 18'd3 : 18'd195075);
    kick(1'b0);
    collect("t2", BYTES, 1'b0, span);
    check_done("t2");

    // 3: all 0xFF x all 0x02 -> 1530 (unsigned) or -6 (signed)
    b_in = '{default: 8'h02};
    for (int e = 0; e < 9; e++) push_elem(SGN ? 18'h3FFFA : 18'd1530);
    kick(1'b0);
    collect("t3", BYTES, 1'b0, span);
    check_done("t3");

    // 4: general matrices with a randomly stalling sink
    a_in = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    b_in = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    push_elem(18'd30);  push_elem(18'd24);  push_elem(18'd18);
    push_elem(18'd84);  push_elem(18'd69);  push_elem(18'd54);
    push_elem(18'd138); push_elem(18'd114); push_elem(18'd90);
    kick(1'b0);
    collect("t4", BYTES, 1'b1, span);
    check_done("t4");

    // 5: retrigger mid-MAC and a held level are ignored; operand changes after
    //    the trigger do not matter; a fresh rising edge starts a new pass.
    push_elem(18'd30);  push_elem(18'd24);  push_elem(18'd18);
    push_elem(18'd84);  push_elem(18'd69);  push_elem(18'd54);
    push_elem(18'd138); push_elem(18'd114); push_elem(18'd90);
    kick(1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a_in  = '{default: 8'h00};
    repeat (2) @(negedge clk);
    check("t5_still_mac", 32'(state_dbg), 32'(MAC));
    collect("t5a", BYTES, 1'b1, span);
    check_done("t5a");
    repeat (5) @(negedge clk);
    check("t5_held_finished", 32'(finished), 32'd1);
    check("t5_held_busy", 32'(busy), 32'd0);
    start = 1'b0;
    for (int e = 0; e < 9; e++) push_elem(18'd0);
    kick(1'b0);
    collect("t5b", BYTES, 1'b0, span);
    check_done("t5b");

    // 6: asynchronous reset in the middle of the stream, then a clean pass
    a_in = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    b_in = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    for (int e = 1; e <= 9; e++) push_elem(18'(e));
    kick(1'b0);
    collect("t6a", 10, 1'b0, span);
    @(negedge clk);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_finished", 32'(finished), 32'd0);
    check("t6_rst_state", 32'(state_dbg), 32'(IDLE));
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("t6_rst_hold_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    a_in = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    b_in = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    push_elem(18'd30);  push_elem(18'd24);  push_elem(18'd18);
    push_elem(18'd84);  push_elem(18'd69);  push_elem(18'd54);
    push_elem(18'd138); push_elem(18'd114); push_elem(18'd90);
    kick(1'b0);
    collect("t6b", BYTES, 1'b1, span);
    check_done("t6b");
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
